// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: drives the SRAM-like fetch bus, holds one instruction for ID and
// drops responses of cancelled requests. Define IF_ADEF_CHECK_EN to trap misaligned fetch PCs.
module if_fetch_ctrl #(
    parameter logic [31:0] PC_RESET    = 32'h1C00_0000,
    parameter int          MAX_DISCARD = 3
) (
    input  logic        aclk,
    input  logic        reset,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        if_flush,
    input  logic [31:0] flush_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        id_allow_in,
    output logic        if_valid_out,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_ready_go,
    output logic        error_inst_in_if
`ifdef IF_ADEF_CHECK_EN
    ,
    output logic        if_adef
`endif
);

    localparam int CW = $clog2(MAX_DISCARD + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state_reg;
    logic [31:0]   fetch_pc_reg;
    logic [31:0]   req_pc_reg;
    logic [31:0]   redir_pc_reg;
    logic [CW-1:0] discard_cnt_reg;
    logic [CW-1:0] discard_cnt_next;
    logic          redirect_pending_reg;
    logic          req_hold_reg;
    logic          if_valid_reg;
    logic [31:0]   if_pc_reg;
    logic [31:0]   if_inst_reg;

    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          consume;
    logic          stale_ok;
    logic          live_ok;
    logic          cnt_full;
    logic          misaligned;
    logic          can_issue;
    logic          accept;
    logic          cancel_live;
    logic          cancel_issue;

`ifdef IF_ADEF_CHECK_EN
    logic          adef_done_reg;
    logic          if_adef_reg;

    assign misaligned = |fetch_pc_reg[1:0];
    assign inst_addr  = fetch_pc_reg;
    assign if_adef    = if_adef_reg;
`else
    assign misaligned = 1'b0;
    assign inst_addr  = {fetch_pc_reg[31:2], 2'b00};
`endif

    assign redirect    = if_flush | br_taken;
    assign redirect_pc = if_flush ? flush_pc : br_target;
    assign consume     = if_valid_reg & id_allow_in;
    assign stale_ok    = inst_data_ok & (discard_cnt_reg != '0);
    assign live_ok     = inst_data_ok & (discard_cnt_reg == '0) & (state_reg == WAIT) & ~if_valid_reg;
    assign cnt_full    = (discard_cnt_reg == CW'(MAX_DISCARD));

    // A new request only goes out if its response is guaranteed a free buffer slot;
    // once raised it is held until accepted regardless of the buffer or redirects.
    assign can_issue = ~cnt_full & ~misaligned & (~if_valid_reg | id_allow_in);
    assign inst_req  = (state_reg == REQ) & (req_hold_reg | can_issue);
    assign accept    = inst_req & inst_addr_ok;

    // In WAIT with an empty buffer the live request is still in flight unless it returns now.
    assign cancel_live      = redirect & (state_reg == WAIT) & ~if_valid_reg & ~live_ok;
    assign cancel_issue     = accept & (redirect | redirect_pending_reg);
    assign discard_cnt_next = discard_cnt_reg - CW'(stale_ok) + CW'(cancel_live | cancel_issue);

    assign if_valid_out     = if_valid_reg;
    assign if_pc            = if_pc_reg;
    assign if_inst          = if_inst_reg;
    assign if_ready_go      = if_valid_reg;
    assign error_inst_in_if = (state_reg == WAIT) | ((state_reg == REQ) & inst_addr_ok) | if_valid_reg;

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_reg            <= IDLE;
            fetch_pc_reg         <= PC_RESET;
            req_pc_reg           <= PC_RESET;
            redir_pc_reg         <= PC_RESET;
            discard_cnt_reg      <= '0;
            redirect_pending_reg <= 1'b0;
            req_hold_reg         <= 1'b0;
            if_valid_reg         <= 1'b0;
            if_pc_reg            <= '0;
            if_inst_reg          <= '0;
`ifdef IF_ADEF_CHECK_EN
            adef_done_reg        <= 1'b0;
            if_adef_reg          <= 1'b0;
`endif
        end else begin
            discard_cnt_reg <= discard_cnt_next;
            if (consume)
                if_valid_reg <= 1'b0;
`ifdef IF_ADEF_CHECK_EN
            if (consume)
                if_adef_reg <= 1'b0;
            if (redirect) begin
                adef_done_reg <= 1'b0;
                if_adef_reg   <= 1'b0;
            end
`endif
            case (state_reg)
                IDLE: begin
                    state_reg <= REQ;
                    if (redirect)
                        fetch_pc_reg <= redirect_pc;
                end
                REQ: begin
                    req_hold_reg <= inst_req & ~inst_addr_ok;
                    if (redirect)
                        if_valid_reg <= 1'b0;
                    if (accept) begin
                        redirect_pending_reg <= 1'b0;
                        if (redirect)
                            fetch_pc_reg <= redirect_pc;
                        else if (redirect_pending_reg)
                            fetch_pc_reg <= redir_pc_reg;
                        else begin
                            req_pc_reg   <= fetch_pc_reg;
                            fetch_pc_reg <= fetch_pc_reg + 32'd4;
                            state_reg    <= WAIT;
                        end
                    end else if (redirect) begin
                        // A raised request must stay unchanged; remember the target instead.
                        if (inst_req) begin
                            redirect_pending_reg <= 1'b1;
                            redir_pc_reg         <= redirect_pc;
                        end else begin
                            fetch_pc_reg <= redirect_pc;
                        end
                    end
`ifdef IF_ADEF_CHECK_EN
                    else if (misaligned & ~adef_done_reg) begin
                        if_valid_reg  <= 1'b1;
                        if_pc_reg     <= fetch_pc_reg;
                        if_inst_reg   <= '0;
                        if_adef_reg   <= 1'b1;
                        adef_done_reg <= 1'b1;
                    end
`endif
                end
                WAIT: begin
                    if (redirect) begin
                        fetch_pc_reg <= redirect_pc;
                        if_valid_reg <= 1'b0;
                        state_reg    <= REQ;
                    end else if (live_ok) begin
                        if_valid_reg <= 1'b1;
                        if_pc_reg    <= req_pc_reg;
                        if_inst_reg  <= inst_rdata;
                        if (id_allow_in)
                            state_reg <= REQ;
                    end else if (consume) begin
                        state_reg <= REQ;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
